// File: rtl/mem_dump_tx_pkg.sv
// Shared types and constants for the memory-to-UART dump engine.
// Holds the controller state encoding and the 8N1 frame shape.
package mem_dump_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        NEXT,
        FIN
    } state_e;

    localparam int   FRAME_BITS       = 10;
    localparam logic START_LVL        = 1'b0;
    localparam logic STOP_LVL         = 1'b1;
    localparam int   DEFAULT_CLK_DIV  = 434;
    localparam int   DEFAULT_READ_LAT = 2;

endpackage

// File: rtl/mem_dump_tx_if.sv
// Command, memory-port and UART-side signals of the dump engine.
// The master modport is the dump engine itself, the slave modport is its environment.
interface mem_dump_tx_if;
    import mem_dump_tx_pkg::*;

    // Handshake: START is a one-cycle request that takes effect only while
    // BUSY is low (engine idle); START_ADDR/LENGTH are sampled in that same
    // cycle. BUSY then stays high until the cycle DONE pulses. The memory
    // side has no ready: R_DATA must be valid READ_LAT cycles after R_SELECT
    // rises and stay valid while R_SELECT is held.
    logic        START;
    logic [15:0] START_ADDR;
    logic [15:0] LENGTH;
    logic [15:0] R_ADDRESS;
    logic        R_SELECT;
    logic [7:0]  R_DATA;
    logic        BUS_HOLD;
    logic        TX;
    logic        BUSY;
    logic        DONE;
    state_e      STATE;

    modport master (
        input  START, START_ADDR, LENGTH, R_DATA,
        output R_ADDRESS, R_SELECT, BUS_HOLD, TX, BUSY, DONE, STATE
    );

    modport slave (
        output START, START_ADDR, LENGTH, R_DATA,
        input  R_ADDRESS, R_SELECT, BUS_HOLD, TX, BUSY, DONE, STATE
    );

endinterface

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: LOAD starts a frame with DATA, TX_DONE marks the last
// cycle of the stop bit. TX comes straight from a flop.
module uart_tx_core
    import mem_dump_tx_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOAD,
    input  logic [7:0] DATA,
    output logic       TX,
    output logic       TX_DONE
);

    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shreg;   // bits still to send after the one on tx_q
    logic        active;
    logic        tx_q;
    logic        bit_end;
    logic        last_bit;

    assign bit_end  = active && (baud_cnt == 16'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));
    assign TX_DONE  = bit_end && last_bit;
    assign TX       = tx_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            active   <= 1'b0;
            tx_q     <= STOP_LVL;
        end else if (LOAD) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= {STOP_LVL, DATA};
            active   <= 1'b1;
            tx_q     <= START_LVL;
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (last_bit) begin
                active <= 1'b0;
                tx_q   <= STOP_LVL;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx_q    <= shreg[0];
                shreg   <= {STOP_LVL, shreg[8:1]};
            end
        end else if (active) begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Dumps LENGTH bytes of memory from START_ADDR over the UART TX line,
// holding the CPU bus only for the fixed-latency read of each byte.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int CLK_DIV  = DEFAULT_CLK_DIV,
    parameter int READ_LAT = DEFAULT_READ_LAT
) (
    input  logic          CLK,
    input  logic          RST_N,
    mem_dump_tx_if.master bus
);

    state_e      state;
    state_e      next_state;
    logic [15:0] addr;
    logic [15:0] remaining;
    logic [3:0]  lat_cnt;
    logic        lat_hit;
    logic        busy_q;
    logic        done_q;
    logic        load;
    logic        tx_done;

    assign lat_hit = (lat_cnt == 4'(READ_LAT));

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE:    if (bus.START) next_state = (bus.LENGTH == 16'd0) ? FIN : FETCH;
            FETCH:   if (lat_hit) begin
                         load       = 1'b1;
                         next_state = SEND;
                     end
            SEND:    if (tx_done) next_state = NEXT;
            NEXT:    next_state = (remaining == 16'd1) ? FIN : FETCH;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    // DONE and the BUSY release are registered so both change on the edge leaving FIN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            lat_cnt <= (state == FETCH && !lat_hit) ? lat_cnt + 4'd1 : 4'd0;
            done_q  <= (state == FIN);
            if (state == IDLE && bus.START) begin
                addr      <= bus.START_ADDR;
                remaining <= bus.LENGTH;
                busy_q    <= 1'b1;
            end
            if (state == NEXT) begin
                addr      <= addr + 16'd1;
                remaining <= remaining - 16'd1;
            end
            if (state == FIN) busy_q <= 1'b0;
        end
    end

    assign bus.R_ADDRESS = addr;
    assign bus.R_SELECT  = (state == FETCH);
    assign bus.BUS_HOLD  = (state == FETCH);
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.STATE     = state;

    uart_tx_core #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx_core (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .LOAD    (load),
        .DATA    (bus.R_DATA),
        .TX      (bus.TX),
        .TX_DONE (tx_done)
    );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: two instances (CLK_DIV=4/READ_LAT=2 and
// CLK_DIV=2/READ_LAT=1) checked cycle by cycle against a frame-level model.
module tb_mem_dump_tx;
    import mem_dump_tx_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks;
    int   passed;
    int   sel;

    logic [7:0] mem [0:65535];
    logic       obs_tx[$];
    logic [15:0] obs_addr[$];

    mem_dump_tx_if bus_a ();
    mem_dump_tx_if bus_b ();

    mem_dump_tx #(.CLK_DIV(4), .READ_LAT(2)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
    mem_dump_tx #(.CLK_DIV(2), .READ_LAT(1)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- memory model: data valid READ_LAT cycles after R_SELECT rises
    logic [7:0] junk_a, junk_b;
    logic [3:0] scnt_a, scnt_b;
    always @(posedge CLK) begin
        junk_a <= 8'($urandom);
        junk_b <= 8'($urandom);
        scnt_a <= bus_a.R_SELECT ? scnt_a + 4'd1 : 4'd0;
        scnt_b <= bus_b.R_SELECT ? scnt_b + 4'd1 : 4'd0;
    end
    assign bus_a.R_DATA = (bus_a.R_SELECT && scnt_a >= 4'd2) ? mem[bus_a.R_ADDRESS] : junk_a;
    assign bus_b.R_DATA = (bus_b.R_SELECT && scnt_b >= 4'd1) ? mem[bus_b.R_ADDRESS] : junk_b;

    logic        tx_m, busy_m, done_m, rsel_m, hold_m;
    logic [15:0] raddr_m;
    assign tx_m    = (sel == 1) ? bus_b.TX        : bus_a.TX;
    assign busy_m  = (sel == 1) ? bus_b.BUSY      : bus_a.BUSY;
    assign done_m  = (sel == 1) ? bus_b.DONE      : bus_a.DONE;
    assign rsel_m  = (sel == 1) ? bus_b.R_SELECT  : bus_a.R_SELECT;
    assign hold_m  = (sel == 1) ? bus_b.BUS_HOLD  : bus_a.BUS_HOLD;
    assign raddr_m = (sel == 1) ? bus_b.R_ADDRESS : bus_a.R_ADDRESS;

    // ---------------- driver tasks ----------------
    task automatic drive_start(input int s, input logic v, input logic [15:0] a, input logic [15:0] n);
        if (s == 1) begin
            bus_b.START = v; bus_b.START_ADDR = a; bus_b.LENGTH = n;
        end else begin
            bus_a.START = v; bus_a.START_ADDR = a; bus_a.LENGTH = n;
        end
    endtask

    // Launches one dump and checks every output against the frame-level model.
    task automatic run_dump(input int s, input logic [15:0] a, input logic [15:0] n,
                            input int restart_at, input string name);
        int   cd, rl, exp_len, done_idx, done_cnt, hold_cnt, bad_tx, bad_addr;
        logic prev_sel, busy_ok;
        logic exp_tx[$];
        logic [15:0] exp_addr[$];
        sel = s;
        cd  = (s == 1) ? 2 : 4;
        rl  = (s == 1) ? 1 : 2;
        for (int b = 0; b < int'(n); b++) begin
            logic [7:0] d;
            d = mem[16'(a + b)];
            exp_addr.push_back(16'(a + b));
            repeat (rl + 1) exp_tx.push_back(1'b1);
            for (int j = 0; j < 10; j++) begin
                logic v;
                v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
                repeat (cd) exp_tx.push_back(v);
            end
            exp_tx.push_back(1'b1);
        end
        exp_tx.push_back(1'b1);
        exp_len = exp_tx.size();

        @(negedge CLK);
        drive_start(s, 1'b1, a, n);
        @(posedge CLK);
        @(negedge CLK);
        drive_start(s, 1'b0, a, n);
        obs_tx.delete();
        obs_addr.delete();
        prev_sel = 1'b0; busy_ok = 1'b1;
        done_idx = -1; done_cnt = 0; hold_cnt = 0;
        for (int i = 0; i < exp_len + 4; i++) begin
            if (i < exp_len) obs_tx.push_back(tx_m);
            if (rsel_m && !prev_sel) obs_addr.push_back(raddr_m);
            prev_sel = rsel_m;
            if (hold_m) hold_cnt++;
            if (done_m) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if ((i < exp_len) != busy_m) busy_ok = 1'b0;
            if (i == restart_at) drive_start(s, 1'b1, 16'($urandom), 16'($urandom_range(1, 9)));
            else drive_start(s, 1'b0, a, n);
            @(negedge CLK);
        end
        drive_start(s, 1'b0, a, n);

        bad_tx = 0;
        for (int i = 0; i < exp_len; i++) if (obs_tx[i] !== exp_tx[i]) bad_tx++;
        bad_addr = (obs_addr.size() == exp_addr.size()) ? 0 : 1000;
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i]) bad_addr++;

        checks++;
        if (bad_tx !== 0) $display("FAIL %s tx_wave: %0d cycles differ, required 0", name, bad_tx);
        else passed++;
        checks++;
        if (bad_addr !== 0) $display("FAIL %s r_address: %0d reads of %0d wrong (1000=count), required 0", name, bad_addr, n);
        else passed++;
        checks++;
        if (hold_cnt !== int'(n) * (rl + 1)) $display("FAIL %s bus_hold: %0d cycles, required %0d", name, hold_cnt, int'(n) * (rl + 1));
        else passed++;
        checks++;
        if (done_idx !== exp_len) $display("FAIL %s done_time: cycle %0d, required %0d", name, done_idx, exp_len);
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL %s done_count: %0d pulses, required 1", name, done_cnt);
        else passed++;
        checks++;
        if (busy_ok !== 1'b1) $display("FAIL %s busy_profile: got %b, required 1", name, busy_ok);
        else passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({bus_a.TX, bus_a.BUSY, bus_a.DONE, bus_a.R_SELECT, bus_a.BUS_HOLD} !== 5'b10000)
            $display("FAIL reset_outputs_a: got %b, required 10000",
                     {bus_a.TX, bus_a.BUSY, bus_a.DONE, bus_a.R_SELECT, bus_a.BUS_HOLD});
        else passed++;
        checks++;
        if (bus_a.R_ADDRESS !== 16'h0000 || bus_a.STATE !== IDLE)
            $display("FAIL reset_addr_state_a: addr %h state %0d, required 0000 / IDLE", bus_a.R_ADDRESS, bus_a.STATE);
        else passed++;
        checks++;
        if ({bus_b.TX, bus_b.BUSY, bus_b.DONE, bus_b.R_SELECT, bus_b.BUS_HOLD} !== 5'b10000)
            $display("FAIL reset_outputs_b: got %b, required 10000",
                     {bus_b.TX, bus_b.BUSY, bus_b.DONE, bus_b.R_SELECT, bus_b.BUS_HOLD});
        else passed++;
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        mem[16'h1000] = 8'hA5;
        run_dump(0, 16'h1000, 16'd1, -1, "single_a5");
        for (int j = 0; j < 10; j++) frame[j] = obs_tx[3 + j * 4 + 2];
        checks++;
        if (frame !== 10'b1101001010) $display("FAIL single_a5 frame_bits: got %b, required 1101001010 (bit9..bit0)", frame);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        int starts[$];
        int i, bad, bad_gap;
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
        exp_q = '{8'h11, 8'h22, 8'h33};
        run_dump(0, 16'hFFFE, 16'd3, -1, "wrap");
        i = 0;
        while (i < obs_tx.size()) begin
            if (obs_tx[i] == 1'b0) begin
                logic [7:0] byt;
                starts.push_back(i);
                for (int j = 0; j < 8; j++) byt[j] = obs_tx[i + (j + 1) * 4 + 2];
                got.push_back(byt);
                i += 40;
            end else i++;
        end
        bad = (got.size() == exp_q.size()) ? 0 : 1000;
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) if (got[k] !== exp_q[k]) bad++;
        checks++;
        if (bad !== 0) $display("FAIL wrap decoded_bytes: %0d wrong (1000=count), required 0", bad);
        else passed++;
        bad_gap = (starts.size() == 3) ? 0 : 1000;
        for (int k = 1; k < starts.size(); k++) if (starts[k] - (starts[k-1] + 40) !== 4) bad_gap++;
        checks++;
        if (bad_gap !== 0) $display("FAIL wrap frame_gap: %0d gaps wrong (1000=count), required 0", bad_gap);
        else passed++;
    endtask

    task automatic test_length_zero();
        run_dump(0, 16'h4321, 16'd0, -1, "length_zero");
    endtask

    task automatic test_busy_restart();
        run_dump(0, 16'h3000, 16'd2, 10, "busy_restart");
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        mem[16'h5000] = 8'h55;
        @(negedge CLK);
        drive_start(0, 1'b1, 16'h5000, 16'd2);
        @(posedge CLK);
        @(negedge CLK);
        drive_start(0, 1'b0, 16'h5000, 16'd2);
        repeat (20) @(negedge CLK);
        checks++;
        if (tx_m !== 1'b0) $display("FAIL mid_frame_bit3: tx %b, required 0", tx_m);
        else passed++;
        #1 RST_N = 1'b0;
        #1;
        checks++;
        if ({bus_a.TX, bus_a.BUSY, bus_a.R_SELECT} !== 3'b100 || bus_a.STATE !== IDLE)
            $display("FAIL async_reset: tx/busy/rsel %b state %0d, required 100 / IDLE",
                     {bus_a.TX, bus_a.BUSY, bus_a.R_SELECT}, bus_a.STATE);
        else passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        mem[16'h2000] = 8'h3C;
        run_dump(0, 16'h2000, 16'd1, -1, "post_reset");
    endtask

    task automatic test_back_to_back();
        run_dump(1, 16'($urandom), 16'd4, -1, "fast_len4");
        for (int r = 0; r < 3; r++)
            run_dump(r % 2, 16'($urandom), 16'($urandom_range(1, 3)), -1, "random");
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        checks = 0; passed = 0; sel = 0;
        RST_N = 1'b0;
        drive_start(0, 1'b0, 16'h0, 16'h0);
        drive_start(1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
        repeat (3) @(negedge CLK);
        test_reset();
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        test_single_byte();
        test_wrap();
        test_length_zero();
        test_busy_restart();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
